// File: rtl/packet_framer.sv
`timescale 1ns/1ps
// packet_framer: frames TLP/DLLP byte streams into STP/SDP ... END/EDB K-symbol streams,
// with nullification, length and underrun handling and registered one-cycle error pulses.
module packet_framer #(
    parameter int MAX_TLP_BYTES = 4096,
    parameter int DLLP_BYTES    = 6
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tx_en,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    input  logic [1:0] in_kind,
    input  logic       in_last,
    input  logic       in_abort,
    output logic       in_ready,
    output logic [7:0] out_data,
    output logic       out_dk,
    output logic       out_valid,
    output logic [1:0] out_kind,
    output logic       err_kind,
    output logic       err_len,
    output logic       err_underrun
);
    localparam int CNT_MAX = MAX_TLP_BYTES > DLLP_BYTES ? MAX_TLP_BYTES : DLLP_BYTES;
    localparam int CW = $clog2(CNT_MAX + 1);
    localparam logic [7:0] SYM_STP = 8'b111_11011;
    localparam logic [7:0] SYM_SDP = 8'b010_11100;
    localparam logic [7:0] SYM_END = 8'b111_11101;
    localparam logic [7:0] SYM_EDB = 8'b111_11110;
    localparam logic [7:0] SYM_PAD = 8'b111_10111;
    localparam logic [1:0] KIND_TLP  = 2'b01;
    localparam logic [1:0] KIND_DLLP = 2'b10;

    typedef enum logic [2:0] {S_IDLE, S_PAYLOAD, S_END, S_EDB, S_DISCARD} state_t;

    state_t        r_state, w_state_nxt;
    logic [CW-1:0] r_cnt, w_cnt_nxt, w_cnt_inc;
    logic [1:0]    r_kind, w_kind_nxt, w_okind;
    logic          r_drop, w_drop_nxt;
    logic [7:0]    w_data;
    logic          w_dk, w_ek, w_el, w_eu;
    logic          w_tlp_full, w_dllp_full;

    assign in_ready    = tx_en && (r_state == S_PAYLOAD || r_state == S_DISCARD);
    assign w_cnt_inc   = r_cnt + 1'b1;
    assign w_tlp_full  = w_cnt_inc == CW'(MAX_TLP_BYTES);
    assign w_dllp_full = w_cnt_inc == CW'(DLLP_BYTES);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_kind_nxt  = r_kind;
        w_drop_nxt  = r_drop;
        w_data      = SYM_PAD;
        w_dk        = 1'b1;
        w_okind     = 2'b00;
        w_ek        = 1'b0;
        w_el        = 1'b0;
        w_eu        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (in_valid && (in_kind == KIND_TLP || in_kind == KIND_DLLP)) begin
                    w_kind_nxt  = in_kind;
                    w_okind     = in_kind;
                    w_data      = in_kind == KIND_TLP ? SYM_STP : SYM_SDP;
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_PAYLOAD;
                end else if (in_valid) begin
                    w_ek        = 1'b1;
                    w_state_nxt = S_DISCARD;
                end
            end
            S_PAYLOAD: begin
                w_okind = r_kind;
                w_data  = SYM_EDB;
                if (!in_valid) begin
                    w_eu        = 1'b1;
                    w_state_nxt = S_DISCARD;
                end else if (in_abort) begin
                    w_state_nxt = in_last ? S_IDLE : S_DISCARD;
                end else begin
                    w_data    = in_data;
                    w_dk      = 1'b0;
                    w_cnt_nxt = w_cnt_inc;
                    if (r_kind == KIND_TLP) begin
                        if (in_last) begin
                            w_state_nxt = S_END;
                        end else if (w_tlp_full) begin
                            w_el        = 1'b1;
                            w_state_nxt = S_EDB;
                        end
                    end else if (in_last || w_dllp_full) begin
                        // a DLLP always closes with END; a missing last byte leaves the rest to be dropped
                        w_el        = !(in_last && w_dllp_full);
                        w_drop_nxt  = !in_last;
                        w_state_nxt = S_END;
                    end
                end
            end
            S_END: begin
                w_data      = SYM_END;
                w_okind     = r_kind;
                w_drop_nxt  = 1'b0;
                w_state_nxt = r_drop ? S_DISCARD : S_IDLE;
            end
            S_EDB: begin
                w_data      = SYM_EDB;
                w_okind     = r_kind;
                w_state_nxt = S_DISCARD;
            end
            S_DISCARD: begin
                if (in_valid && in_last) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_kind       <= 2'b00;
            r_drop       <= 1'b0;
            out_data     <= 8'h00;
            out_dk       <= 1'b0;
            out_valid    <= 1'b0;
            out_kind     <= 2'b00;
            err_kind     <= 1'b0;
            err_len      <= 1'b0;
            err_underrun <= 1'b0;
        end else begin
            err_kind     <= tx_en && w_ek;
            err_len      <= tx_en && w_el;
            err_underrun <= tx_en && w_eu;
            if (tx_en) begin
                r_state   <= w_state_nxt;
                r_cnt     <= w_cnt_nxt;
                r_kind    <= w_kind_nxt;
                r_drop    <= w_drop_nxt;
                out_data  <= w_data;
                out_dk    <= w_dk;
                out_valid <= 1'b1;
                out_kind  <= w_okind;
            end
        end
    end
endmodule

// File: tb/tb_packet_framer.sv
`timescale 1ns/1ps
// tb_packet_framer: per-cycle vector table, a mid-packet reset sequence, and randomized packets
// checked against a packet-level model of the expected symbol stream.
module tb_packet_framer;
    localparam logic [7:0] STP  = 8'hFB;
    localparam logic [7:0] SDP  = 8'h5C;
    localparam logic [7:0] ENDS = 8'hFD;
    localparam logic [7:0] EDB  = 8'hFE;
    localparam logic [7:0] PAD  = 8'hF7;
    localparam int M = 4;
    localparam int D = 6;

    typedef struct packed {
        logic       tx, v;
        logic [7:0] d;
        logic [1:0] k;
        logic       l, ab, rdy;
        logic [7:0] od;
        logic       dk;
        logic [1:0] ok;
        logic [2:0] er;
    } vec_t;

    logic clk = 1'b0, rst_n = 1'b0, tx_en = 1'b0, in_valid = 1'b0, in_last = 1'b0, in_abort = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic [1:0] in_kind = 2'b00;
    logic a_ready, a_dk, a_valid, a_ek, a_el, a_eu;
    logic b_ready, b_dk, b_valid, b_ek, b_el, b_eu;
    logic [7:0] a_data, b_data;
    logic [1:0] a_kind, b_kind;

    int n_cmp = 0, n_bad = 0;
    vec_t tv[$];
    logic [13:0] exp_q[$];
    logic [14:0] prev;
    bit trailing;
    logic [1:0] pk_kind;
    int pk_n, pk_a, pk_g;
    logic [7:0] pk_d[16];

    packet_framer u_dut (
        .clk(clk), .rst_n(rst_n), .tx_en(tx_en), .in_valid(in_valid), .in_data(in_data),
        .in_kind(in_kind), .in_last(in_last), .in_abort(in_abort), .in_ready(a_ready),
        .out_data(a_data), .out_dk(a_dk), .out_valid(a_valid), .out_kind(a_kind),
        .err_kind(a_ek), .err_len(a_el), .err_underrun(a_eu)
    );

    packet_framer #(.MAX_TLP_BYTES(M), .DLLP_BYTES(D)) u_small (
        .clk(clk), .rst_n(rst_n), .tx_en(tx_en), .in_valid(in_valid), .in_data(in_data),
        .in_kind(in_kind), .in_last(in_last), .in_abort(in_abort), .in_ready(b_ready),
        .out_data(b_data), .out_dk(b_dk), .out_valid(b_valid), .out_kind(b_kind),
        .err_kind(b_ek), .err_len(b_el), .err_underrun(b_eu)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t vv(logic tx, logic v, logic [7:0] d, logic [1:0] k, logic l, logic ab,
                                logic rdy, logic [7:0] od, logic dk, logic [1:0] ok, logic [2:0] er);
        vec_t r;
        r = '{tx, v, d, k, l, ab, rdy, od, dk, ok, er};
        return r;
    endfunction

    function automatic void push(logic dk, logic [1:0] k, logic [7:0] d, logic [2:0] e);
        exp_q.push_back({dk, k, d, e});
    endfunction

    function automatic void pads(int n);
        for (int i = 0; i < n; i++) push(1'b1, 2'b00, PAD, 3'b000);
    endfunction

    // Expected symbols for one packet, preceded by its idle PADs; the END of the previous
    // packet occupies the first idle cycle when that packet closed with END.
    function automatic void model_pkt(int pre);
        logic [1:0] k;
        bit last, pend;
        k = pk_kind;
        pads(trailing ? (pre > 0 ? pre - 1 : 0) : pre);
        trailing = 0;
        if (k != 2'b01 && k != 2'b10) begin
            push(1'b1, 2'b00, PAD, 3'b100);
            pads(pk_n + (pk_g > 0 ? 1 : 0));
            return;
        end
        push(1'b1, k, k == 2'b01 ? STP : SDP, 3'b000);
        for (int i = 0; i < pk_n; i++) begin
            last = i == pk_n - 1;
            pend = pk_g > i;
            if (i == pk_g) begin
                push(1'b1, k, EDB, 3'b001);
                pads(pk_n - i);
                return;
            end
            if (i == pk_a) begin
                push(1'b1, k, EDB, 3'b000);
                pads(pk_n - 1 - i + int'(pend));
                return;
            end
            if (k == 2'b01) begin
                if (last) begin
                    push(1'b0, k, pk_d[i], 3'b000);
                    push(1'b1, k, ENDS, 3'b000);
                    trailing = 1;
                    return;
                end
                if (i + 1 == M) begin
                    push(1'b0, k, pk_d[i], 3'b010);
                    push(1'b1, k, EDB, 3'b000);
                    pads(pk_n - 1 - i + int'(pend));
                    return;
                end
            end else if (last || i + 1 == D) begin
                push(1'b0, k, pk_d[i], (last && i + 1 == D) ? 3'b000 : 3'b010);
                push(1'b1, k, ENDS, 3'b000);
                trailing = last;
                if (!last) pads(pk_n - 1 - i + int'(pend));
                return;
            end
            push(1'b0, k, pk_d[i], 3'b000);
        end
    endfunction

    task automatic gen_pkt(input int idx);
        int r;
        r = $urandom_range(0, 9);
        pk_kind = r < 6 ? 2'b01 : r < 9 ? 2'b10 : ($urandom_range(0, 1) != 0 ? 2'b11 : 2'b00);
        pk_n = $urandom_range(1, 10);
        pk_a = $urandom_range(0, 4) == 0 ? int'($urandom_range(0, pk_n - 1)) : -1;
        pk_g = (pk_n > 1 && $urandom_range(0, 4) == 0) ? int'($urandom_range(1, pk_n - 1)) : -1;
        for (int i = 0; i < 16; i++) pk_d[i] = 8'($urandom);
        if (idx < 4) begin
            pk_kind = idx == 0 ? 2'b01 : 2'b10;
            pk_n = idx == 0 ? 6 : idx == 1 ? 6 : idx == 2 ? 8 : 3;
            pk_a = -1;
            pk_g = -1;
        end
    endtask

    task automatic tick_check();
        logic was_tx;
        logic [14:0] cur;
        was_tx = tx_en;
        @(posedge clk);
        #1;
        cur = {b_valid, b_dk, b_kind, b_data, b_ek, b_el, b_eu};
        if (was_tx) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL rnd extra symbol: got %h expected none", cur);
            end else begin
                check("rnd symbol", 16'(cur), 16'({1'b1, exp_q.pop_front()}));
            end
        end else begin
            check("rnd hold", 16'(cur[14:3]), 16'(prev[14:3]));
        end
        prev = cur;
    endtask

    initial begin
        vec_t t;
        int pre, idx, guard;
        bit gap_done, gap, took;

        tv.push_back(vv(1, 0, 8'h00, 2'd0, 0, 0, 0, PAD,   1, 2'd0, 3'b000));
        tv.push_back(vv(1, 1, 8'hAA, 2'd1, 0, 0, 0, STP,   1, 2'd1, 3'b000));
        tv.push_back(vv(1, 1, 8'hAA, 2'd1, 0, 0, 1, 8'hAA, 0, 2'd1, 3'b000));
        tv.push_back(vv(1, 1, 8'hBB, 2'd1, 0, 0, 1, 8'hBB, 0, 2'd1, 3'b000));
        tv.push_back(vv(1, 1, 8'hCC, 2'd1, 1, 0, 1, 8'hCC, 0, 2'd1, 3'b000));
        tv.push_back(vv(1, 0, 8'h00, 2'd0, 0, 0, 0, ENDS,  1, 2'd1, 3'b000));
        tv.push_back(vv(1, 0, 8'h00, 2'd0, 0, 0, 0, PAD,   1, 2'd0, 3'b000));
        tv.push_back(vv(1, 1, 8'hC1, 2'd1, 0, 0, 0, STP,   1, 2'd1, 3'b000));
        tv.push_back(vv(0, 1, 8'hC1, 2'd1, 0, 0, 0, STP,   1, 2'd1, 3'b000));
        tv.push_back(vv(1, 1, 8'hC1, 2'd1, 0, 0, 1, 8'hC1, 0, 2'd1, 3'b000));
        tv.push_back(vv(0, 1, 8'hC2, 2'd1, 1, 0, 0, 8'hC1, 0, 2'd1, 3'b000));
        tv.push_back(vv(1, 1, 8'hC2, 2'd1, 1, 0, 1, 8'hC2, 0, 2'd1, 3'b000));
        tv.push_back(vv(0, 0, 8'h00, 2'd0, 0, 0, 0, 8'hC2, 0, 2'd1, 3'b000));
        tv.push_back(vv(1, 0, 8'h00, 2'd0, 0, 0, 0, ENDS,  1, 2'd1, 3'b000));
        tv.push_back(vv(1, 0, 8'h00, 2'd0, 0, 0, 0, PAD,   1, 2'd0, 3'b000));
        tv.push_back(vv(1, 1, 8'h11, 2'd1, 0, 0, 0, STP,   1, 2'd1, 3'b000));
        tv.push_back(vv(1, 1, 8'h11, 2'd1, 0, 0, 1, 8'h11, 0, 2'd1, 3'b000));
        tv.push_back(vv(1, 1, 8'h22, 2'd1, 0, 0, 1, 8'h22, 0, 2'd1, 3'b000));
        tv.push_back(vv(1, 0, 8'h00, 2'd1, 0, 0, 1, EDB,   1, 2'd1, 3'b001));
        tv.push_back(vv(1, 1, 8'h33, 2'd1, 0, 0, 1, PAD,   1, 2'd0, 3'b000));
        tv.push_back(vv(1, 1, 8'h44, 2'd1, 1, 0, 1, PAD,   1, 2'd0, 3'b000));
        tv.push_back(vv(1, 0, 8'h00, 2'd0, 0, 0, 0, PAD,   1, 2'd0, 3'b000));
        tv.push_back(vv(1, 1, 8'h55, 2'd1, 0, 0, 0, STP,   1, 2'd1, 3'b000));
        tv.push_back(vv(1, 1, 8'h55, 2'd1, 0, 0, 1, 8'h55, 0, 2'd1, 3'b000));
        tv.push_back(vv(1, 1, 8'h66, 2'd1, 0, 1, 1, EDB,   1, 2'd1, 3'b000));
        tv.push_back(vv(1, 1, 8'h77, 2'd1, 0, 0, 1, PAD,   1, 2'd0, 3'b000));
        tv.push_back(vv(1, 1, 8'h88, 2'd1, 1, 0, 1, PAD,   1, 2'd0, 3'b000));
        tv.push_back(vv(1, 0, 8'h00, 2'd0, 0, 0, 0, PAD,   1, 2'd0, 3'b000));
        tv.push_back(vv(1, 1, 8'h01, 2'd2, 0, 0, 0, SDP,   1, 2'd2, 3'b000));
        for (int b = 1; b <= 6; b++)
            tv.push_back(vv(1, 1, 8'(b), 2'd2, 0, 0, 1, 8'(b), 0, 2'd2, b == 6 ? 3'b010 : 3'b000));
        tv.push_back(vv(1, 1, 8'h07, 2'd2, 0, 0, 0, ENDS,  1, 2'd2, 3'b000));
        tv.push_back(vv(1, 1, 8'h07, 2'd2, 0, 0, 1, PAD,   1, 2'd0, 3'b000));
        tv.push_back(vv(1, 1, 8'h08, 2'd2, 1, 0, 1, PAD,   1, 2'd0, 3'b000));
        tv.push_back(vv(1, 0, 8'h00, 2'd0, 0, 0, 0, PAD,   1, 2'd0, 3'b000));
        tv.push_back(vv(1, 1, 8'h99, 2'd3, 1, 0, 0, PAD,   1, 2'd0, 3'b100));
        tv.push_back(vv(1, 1, 8'h99, 2'd3, 1, 0, 1, PAD,   1, 2'd0, 3'b000));
        tv.push_back(vv(1, 0, 8'h00, 2'd0, 0, 0, 0, PAD,   1, 2'd0, 3'b000));

        tx_en = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset outputs", 16'({a_valid, a_dk, a_kind, a_data, a_ek, a_el, a_eu}), 16'h0000);
        check("reset ready", 16'(a_ready), 16'h0000);
        rst_n = 1'b1;

        foreach (tv[i]) begin
            t = tv[i];
            tx_en = t.tx; in_valid = t.v; in_data = t.d; in_kind = t.k; in_last = t.l; in_abort = t.ab;
            #1;
            check($sformatf("table ready row %0d", i), 16'(a_ready), 16'(t.rdy));
            @(posedge clk);
            #1;
            check($sformatf("table out row %0d", i), 16'({a_valid, a_dk, a_kind, a_data, a_ek, a_el, a_eu}),
                  16'({1'b1, t.dk, t.ok, t.od, t.er}));
        end

        tx_en = 1'b1; in_valid = 1'b1; in_kind = 2'b01; in_data = 8'hE1; in_last = 1'b0; in_abort = 1'b0;
        @(posedge clk);
        #1;
        check("midrst stp", 16'({a_dk, a_data}), 16'({1'b1, STP}));
        @(posedge clk);
        #1;
        check("midrst byte", 16'({a_dk, a_data}), 16'({1'b0, 8'hE1}));
        in_data = 8'hE2;
        #2 rst_n = 1'b0;
        #1;
        check("midrst outputs", 16'({a_valid, a_dk, a_kind, a_data, a_ek, a_el, a_eu}), 16'h0000);
        check("midrst ready", 16'(a_ready), 16'h0000);
        in_valid = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("midrst release pad", 16'({a_valid, a_dk, a_kind, a_data, a_ek, a_el, a_eu}),
              16'({1'b1, 1'b1, 2'b00, PAD, 3'b000}));

        rst_n = 1'b0;
        @(posedge clk);
        #1;
        prev = '0;
        trailing = 0;
        exp_q.delete();
        rst_n = 1'b1;
        for (int p = 0; p < 80; p++) begin
            gen_pkt(p);
            pre = $urandom_range(0, 2);
            model_pkt(pre);
            guard = 0;
            while (pre > 0 && guard < 100) begin
                tx_en = $urandom_range(0, 3) != 0;
                in_valid = 1'b0; in_last = 1'b0; in_abort = 1'b0;
                #1;
                if (!tx_en) check("rnd ready held", 16'(b_ready), 16'h0000);
                if (tx_en) pre--;
                tick_check();
                guard++;
            end
            idx = 0;
            gap_done = 0;
            while (idx < pk_n && guard < 400) begin
                tx_en = $urandom_range(0, 3) != 0;
                #1;
                gap = !gap_done && idx == pk_g && tx_en && b_ready;
                if (gap) gap_done = 1;
                in_valid = !gap;
                in_data = pk_d[idx];
                in_kind = pk_kind;
                in_last = idx == pk_n - 1;
                in_abort = idx == pk_a;
                took = tx_en && in_valid && b_ready;
                if (!tx_en) check("rnd ready held", 16'(b_ready), 16'h0000);
                tick_check();
                if (took) idx++;
                guard++;
            end
            if (guard >= 400 || pre > 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL rnd progress: packet %0d stalled at byte %0d of %0d", p, idx, pk_n);
            end
        end
        in_valid = 1'b0; in_last = 1'b0; in_abort = 1'b0;
        for (int c = 0; c < 20 && exp_q.size() > 0; c++) begin
            tx_en = 1'b1;
            #1;
            tick_check();
        end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL rnd drain: got %0d symbols left expected 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
